vga_scan_controller: RTL

//  Sequences the horizontal/vertical scan counters of the VGA path. Derives the pixel tick from Clk,

---
 rtl/vga_scan_if.sv | 24 ++
 rtl/vga_scan_controller.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/vga_scan_if.sv
// Scan-controller to pixel-generator bundle: run request in, timing and coordinates out.
interface vga_scan_if #(
    parameter int CW = 10
);
    logic          run;
    logic          busy;
    logic          pix_tick;
    logic          hsync;
    logic          vsync;
    logic          video_on;
    logic [CW-1:0] pixel_x;
    logic [CW-1:0] pixel_y;
    logic          frame_start;

    modport master (
        input  run,
        output busy, pix_tick, hsync, vsync, video_on, pixel_x, pixel_y, frame_start
    );

    modport slave (
        output run,
        input  busy, pix_tick, hsync, vsync, video_on, pixel_x, pixel_y, frame_start
    );
endinterface

// File: rtl/vga_scan_controller.sv
// VGA scan sequencer: pixel-tick divider, horizontal/vertical scan counters and
// sync/blanking decode, with a run/stop handshake that only stops on a frame boundary.
//
//   state | meaning
//   ------+----------------------------------------------------------------
//   IDLE  | not scanning; divider and counters held at 0, syncs high
//   RUN   | scanning; end of frame wraps to (0,0) with frame_start
//   DRAIN | scanning, run dropped; stops at end of frame unless run returns
module vga_scan_controller #(
    parameter int CLK_DIV  = 4,
    parameter int CW       = 10,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       Clk,
    input  logic       Reset,
    vga_scan_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);

    // Phase bounds kept 32 bits wide so a sync window ending at 2**CW still compares correctly.
    localparam int unsigned H_VIS  = H_ACTIVE;
    localparam int unsigned HS_BEG = H_ACTIVE + H_FP;
    localparam int unsigned HS_END = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned V_VIS  = V_ACTIVE;
    localparam int unsigned VS_BEG = V_ACTIVE + V_FP;
    localparam int unsigned VS_END = V_ACTIVE + V_FP + V_SYNC;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] div, div_nxt;
    logic [CW-1:0] h_cnt, h_nxt;
    logic [CW-1:0] v_cnt, v_nxt;
    logic          tick;
    logic          eof;
    logic          fs_nxt;
    logic          busy_nxt;
    logic          tick_nxt;
    logic          hsync_nxt;
    logic          vsync_nxt;
    logic          video_nxt;
    logic [31:0]   h_wide;
    logic [31:0]   v_wide;

    // Next state, divider/counter advance and decode of the outputs for the next cycle
    always_comb begin
        state_nxt = state;
        div_nxt   = div;
        h_nxt     = h_cnt;
        v_nxt     = v_cnt;
        fs_nxt    = 1'b0;
        tick      = (state != IDLE) && (div == DIV_LAST);
        eof       = tick && (h_cnt == H_LAST) && (v_cnt == V_LAST);

        if (state != IDLE) begin
            if (tick) begin
                div_nxt = '0;
                if (h_cnt == H_LAST) begin
                    h_nxt = '0;
                    v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
                end else begin
                    h_nxt = h_cnt + 1'b1;
                end
            end else begin
                div_nxt = div + 1'b1;
            end
        end

        // Counters wrap to (0,0) on the end-of-frame tick, so falling back to IDLE
        // there already leaves them cleared.
        case (state)
            IDLE: begin
                if (bus.run) begin
                    state_nxt = RUN;
                    fs_nxt    = 1'b1;
                end
            end
            RUN: begin
                fs_nxt = eof;
                if (!bus.run) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.run) begin
                    state_nxt = RUN;
                    fs_nxt    = eof;
                end else if (eof) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        h_wide    = 32'(h_nxt);
        v_wide    = 32'(v_nxt);
        busy_nxt  = (state_nxt != IDLE);
        tick_nxt  = busy_nxt && (div_nxt == DIV_LAST);
        hsync_nxt = !(busy_nxt && (h_wide >= HS_BEG) && (h_wide < HS_END));
        vsync_nxt = !(busy_nxt && (v_wide >= VS_BEG) && (v_wide < VS_END));
        video_nxt = busy_nxt && (h_wide < H_VIS) && (v_wide < V_VIS);
    end

    // State, counters and all outputs registered together so syncs match the coordinates
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state           <= IDLE;
            div             <= '0;
            h_cnt           <= '0;
            v_cnt           <= '0;
            bus.busy        <= 1'b0;
            bus.pix_tick    <= 1'b0;
            bus.hsync       <= 1'b1;
            bus.vsync       <= 1'b1;
            bus.video_on    <= 1'b0;
            bus.frame_start <= 1'b0;
        end else begin
            state           <= state_nxt;
            div             <= div_nxt;
            h_cnt           <= h_nxt;
            v_cnt           <= v_nxt;
            bus.busy        <= busy_nxt;
            bus.pix_tick    <= tick_nxt;
            bus.hsync       <= hsync_nxt;
            bus.vsync       <= vsync_nxt;
            bus.video_on    <= video_nxt;
            bus.frame_start <= fs_nxt;
        end
    end

    // Coordinates are the counter registers themselves
    assign bus.pixel_x = h_cnt;
    assign bus.pixel_y = v_cnt;
endmodule
